// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control encodings and op type shared by the ALU files
package mips_alu_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_LUI  = 4'b0011;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_SLTU = 4'b1000;
  localparam alu_op_t ALU_XOR  = 4'b1001;
  localparam alu_op_t ALU_NOR  = 4'b1100;
endpackage

// File: rtl/mips_alu_datapath.sv
// mips_alu_datapath: combinational result/zero/overflow for mips_alu (Overflow under MIPS_ALU_OVERFLOW_EN)
module mips_alu_datapath
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  alu_op_t          ALUControl,
  output logic [WIDTH-1:0] next_result,
`ifdef MIPS_ALU_OVERFLOW_EN
  output logic             next_overflow,
`endif
  output logic             next_zero
);
  localparam int M = WIDTH - 1;
  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             slt;
  logic             sltu;
  assign sub_mode = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT) || (ALUControl == ALU_SLTU);
  assign b_eff    = sub_mode ? ~B : B;
  assign sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
  assign slt      = (A[M] != B[M]) ? A[M] : sum[M];
  assign sltu     = ~sum[WIDTH];
  // Select the result for the current op; unknown codes yield zero
  always_comb begin
    next_result = '0;
    case (ALUControl)
      ALU_AND:  next_result = A & B;
      ALU_OR:   next_result = A | B;
      ALU_ADD:  next_result = sum[M:0];
      ALU_SUB:  next_result = sum[M:0];
      ALU_SLT:  next_result = {{M{1'b0}}, slt};
      ALU_SLTU: next_result = {{M{1'b0}}, sltu};
      ALU_XOR:  next_result = A ^ B;
      ALU_NOR:  next_result = ~(A | B);
      ALU_LUI:  next_result = {B[WIDTH-17:0], 16'h0000};
      default:  next_result = '0;
    endcase
  end
  assign next_zero = (next_result == '0);
`ifdef MIPS_ALU_OVERFLOW_EN
  assign next_overflow = ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB)) &&
                         (A[M] == b_eff[M]) && (sum[M] != A[M]);
`endif
endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit MIPS ALU, one cycle latency (Overflow output under MIPS_ALU_OVERFLOW_EN)
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
`ifdef MIPS_ALU_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic             out_valid
);
  logic [WIDTH-1:0] next_result;
  logic             next_zero;
`ifdef MIPS_ALU_OVERFLOW_EN
  logic             next_overflow;
`endif
  mips_alu_datapath #(.WIDTH(WIDTH)) u_dp (
    .A           (A),
    .B           (B),
    .ALUControl  (alu_op_t'(ALUControl)),
    .next_result (next_result),
`ifdef MIPS_ALU_OVERFLOW_EN
    .next_overflow(next_overflow),
`endif
    .next_zero   (next_zero)
  );
  // Output registers load on valid input and hold otherwise; out_valid tracks in_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      Result    <= '0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
`ifdef MIPS_ALU_OVERFLOW_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result   <= next_result;
        Zero     <= next_zero;
`ifdef MIPS_ALU_OVERFLOW_EN
        Overflow <= next_overflow;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed self-checking bench for mips_alu
module tb_mips_alu;
  import mips_alu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alu_control = '0;
  logic        in_valid = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        out_valid;
`ifdef MIPS_ALU_OVERFLOW_EN
  logic        overflow;
`endif
  int n_checks = 0;
  int n_fail = 0;

  mips_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (a),
    .B         (b),
    .ALUControl(alu_control),
    .in_valid  (in_valid),
    .Result    (result),
    .Zero      (zero),
`ifdef MIPS_ALU_OVERFLOW_EN
    .Overflow  (overflow),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp);
    @(negedge clk);
    a = av;
    b = bv;
    alu_control = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    check({tag, ".valid"}, {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.result", result, 32'h0);
    check("rst.zero", {31'b0, zero}, 32'h1);
    check("rst.valid", {31'b0, out_valid}, 32'h0);
`ifdef MIPS_ALU_OVERFLOW_EN
    check("rst.ovf", {31'b0, overflow}, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    run_op("and",  ALU_AND,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000);
    run_op("or",   ALU_OR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFF0F0F);
    run_op("nor",  ALU_NOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0000F0F0);
    run_op("xor",  ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
    run_op("add",  ALU_ADD,  32'h00000001, 32'h00000001, 32'h00000002);
`ifdef MIPS_ALU_OVERFLOW_EN
    check("add.ovf", {31'b0, overflow}, 32'h0);
`endif
    run_op("sub",  ALU_SUB,  32'h00000002, 32'h00000001, 32'h00000001);
    run_op("sub0", ALU_SUB,  32'h00000001, 32'h00000001, 32'h00000000);
    run_op("addw", ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000);
`ifdef MIPS_ALU_OVERFLOW_EN
    check("addw.ovf", {31'b0, overflow}, 32'h0);
`endif
    run_op("slt1", ALU_SLT,  32'h00000001, 32'h00000002, 32'h00000001);
    run_op("slt2", ALU_SLT,  32'h00000002, 32'h00000001, 32'h00000000);
    run_op("sltn", ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    run_op("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
    run_op("sltr", ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001);
    run_op("sltb", ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000);
    run_op("sltc", ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001);
    run_op("lui",  ALU_LUI,  32'hDEADBEEF, 32'h00001234, 32'h12340000);
    run_op("bad",  4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000);
    run_op("pre",  ALU_OR,   32'h00A00000, 32'h0000000B, 32'h00A0000B);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'h0;
    b = 32'h0;
    alu_control = ALU_AND;
    @(posedge clk);
    #1;
    check("hold.result", result, 32'h00A0000B);
    check("hold.zero", {31'b0, zero}, 32'h0);
    check("hold.valid", {31'b0, out_valid}, 32'h0);
    run_op("mid",  ALU_ADD,  32'h00000010, 32'h00000020, 32'h00000030);
    @(negedge clk);
    reset = 1'b1;
    a = 32'h5;
    b = 32'h6;
    alu_control = ALU_ADD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mrst.result", result, 32'h0);
    check("mrst.zero", {31'b0, zero}, 32'h1);
    check("mrst.valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("mrst2.result", result, 32'h0);
    check("mrst2.valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post", ALU_ADD,  32'h00000005, 32'h00000006, 32'h0000000B);
`ifdef MIPS_ALU_OVERFLOW_EN
    run_op("ovfa", ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000);
    check("ovfa.ovf", {31'b0, overflow}, 32'h1);
    run_op("ovfs", ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF);
    check("ovfs.ovf", {31'b0, overflow}, 32'h1);
    run_op("ovfx", ALU_XOR,  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFE);
    check("ovfx.ovf", {31'b0, overflow}, 32'h0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
